// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: Montgomery-domain left-to-right square-and-multiply sequencer for P = X^E mod M
//   requester side : start (level) / stop (held until start falls), busy, operands X E M R2 num_words, result P
//   mon_prod side  : mp_start (held until mp_stop), mp_A mp_B mp_M mp_num_words, mp_stop, mp_P
module mod_exp_ctrl #(
  parameter int bitLen     = 64,
  parameter int expLen     = 64,
  parameter int countWidth = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [bitLen-1:0]     X,
  input  logic [expLen-1:0]     E,
  input  logic [bitLen-1:0]     M,
  input  logic [bitLen-1:0]     R2,
  input  logic [countWidth-1:0] num_words,
  output logic                  stop,
  output logic [bitLen-1:0]     P,
  output logic                  busy,
  output logic                  mp_start,
  output logic [bitLen-1:0]     mp_A,
  output logic [bitLen-1:0]     mp_B,
  output logic [bitLen-1:0]     mp_M,
  output logic [countWidth-1:0] mp_num_words,
  input  logic                  mp_stop,
  input  logic [bitLen-1:0]     mp_P
);
  localparam int IW = $clog2(expLen) + 1;
  typedef enum logic [2:0] {
    S_IDLE, S_CONV_X, S_CONV_ONE, S_SQUARE, S_MULT, S_NEXT, S_FROM_MONT, S_DONE
  } state_t;
  // PH_FLUSH is the release-style wait on entry from IDLE, so a stale mp_stop is never mistaken for a result
  typedef enum logic [1:0] {PH_FLUSH, PH_ISSUE, PH_RELEASE} phase_t;
  state_t state_q, state_d, op_next;
  phase_t phase_q, phase_d;
  logic [bitLen-1:0] x_q, x_d, m_q, m_d, r2_q, r2_d, xbar_q, xbar_d, acc_q, acc_d, p_q, p_d;
  logic [expLen-1:0] e_q, e_d;
  logic [countWidth-1:0] nw_q, nw_d;
  logic [IW-1:0] idx_q, idx_d;
  logic is_op;
  assign is_op = state_q inside {S_CONV_X, S_CONV_ONE, S_SQUARE, S_MULT, S_FROM_MONT};
  assign mp_start = is_op && phase_q == PH_ISSUE;
  assign stop = state_q == S_DONE;
  assign busy = state_q != S_IDLE && state_q != S_DONE;
  assign P = p_q;
  assign mp_M = m_q;
  assign mp_num_words = nw_q;
  // operands are decoded from registers that only change at capture, so they stay stable while mp_start is high
  always_comb begin
    mp_A = '0;
    mp_B = '0;
    op_next = state_q;
    case (state_q)
      S_CONV_X:    begin mp_A = x_q;   mp_B = r2_q;         op_next = S_CONV_ONE; end
      S_CONV_ONE:  begin mp_A = bitLen'(1); mp_B = r2_q;    op_next = S_SQUARE; end
      S_SQUARE:    begin mp_A = acc_q; mp_B = acc_q;        op_next = e_q[expLen-1] ? S_MULT : S_NEXT; end
      S_MULT:      begin mp_A = acc_q; mp_B = xbar_q;       op_next = S_NEXT; end
      S_FROM_MONT: begin mp_A = acc_q; mp_B = bitLen'(1);   op_next = S_DONE; end
      default: ;
    endcase
  end
  // e_q is shifted left after every bit so the bit under test is always the MSB
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    x_d = x_q;
    m_d = m_q;
    r2_d = r2_q;
    e_d = e_q;
    nw_d = nw_q;
    xbar_d = xbar_q;
    acc_d = acc_q;
    p_d = p_q;
    idx_d = idx_q;
    case (state_q)
      S_IDLE: if (start) begin
        x_d = X;
        m_d = M;
        r2_d = R2;
        e_d = E;
        nw_d = num_words;
        state_d = S_CONV_X;
        phase_d = PH_FLUSH;
      end
      S_NEXT: begin
        state_d = idx_q == '0 ? S_FROM_MONT : S_SQUARE;
        idx_d = idx_q == '0 ? idx_q : idx_q - IW'(1);
        e_d = e_q << 1;
        phase_d = PH_ISSUE;
      end
      S_DONE: if (!start) state_d = S_IDLE;
      default: case (phase_q)
        PH_FLUSH: if (!mp_stop) phase_d = PH_ISSUE;
        PH_ISSUE: if (mp_stop) begin
          phase_d = PH_RELEASE;
          xbar_d = state_q == S_CONV_X ? mp_P : xbar_q;
          p_d = state_q == S_FROM_MONT ? mp_P : p_q;
          acc_d = state_q inside {S_CONV_ONE, S_SQUARE, S_MULT} ? mp_P : acc_q;
        end
        default: if (!mp_stop) begin
          state_d = op_next;
          phase_d = PH_ISSUE;
          idx_d = state_q == S_CONV_ONE ? IW'(expLen - 1) : idx_q;
        end
      endcase
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_FLUSH;
      x_q <= '0;
      m_q <= '0;
      r2_q <= '0;
      e_q <= '0;
      nw_q <= '0;
      xbar_q <= '0;
      acc_q <= '0;
      p_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      x_q <= x_d;
      m_q <= m_d;
      r2_q <= r2_d;
      e_q <= e_d;
      nw_q <= nw_d;
      xbar_q <= xbar_d;
      acc_q <= acc_d;
      p_q <= p_d;
      idx_q <= idx_d;
    end
  end
endmodule
